// File: rtl/encoder_period_frontend_if.sv
// Measurement bundle leaving the encoder front end.
// Carries period, position and status to the speed loop.
interface encoder_period_frontend_if #(
  parameter int DATA_WIDTH = 16
);
  logic [DATA_WIDTH-1:0] period_speed;
  logic                  period_valid;
  logic [1:0]            direction;
  logic [DATA_WIDTH-1:0] position;
  logic                  stalled;
  logic                  illegal_edge;

  modport master (
    output period_speed,
    output period_valid,
    output direction,
    output position,
    output stalled,
    output illegal_edge
  );

  modport slave (
    input period_speed,
    input period_valid,
    input direction,
    input position,
    input stalled,
    input illegal_edge
  );
endinterface

// File: rtl/encoder_period_frontend.sv
// Quadrature encoder conditioning, decode and A-period averaging.
// Feeds period_speed of the BLDC speed controller.
module encoder_period_frontend #(
  parameter int DATA_WIDTH = 16,
  parameter int DEBOUNCE = 3,
  parameter int AVG_LOG2 = 2,
  parameter logic [DATA_WIDTH-1:0] TIMEOUT = 16'hFFF0
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic encoder_a,
  input  logic encoder_b,
  encoder_period_frontend_if.master meas
);
  localparam int NAVG = 1 << AVG_LOG2;
  localparam int SW = DATA_WIDTH + AVG_LOG2;
  localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [DATA_WIDTH-1:0] ONES = '1;
  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE
  } state_t;

  logic a_s1, a_s2, b_s1, b_s2;
  logic [DEBOUNCE-2:0] a_sh, b_sh;
  logic [DEBOUNCE-1:0] a_win, b_win;
  logic a_f, b_f;
  logic [1:0] ab_p;

  logic [1:0] idx_p, idx_c, idx_d;
  logic step_fwd, step_rev, step_ill;
  logic a_rise;

  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic take, arm_hit, stall_hit;
  logic first_q;

  logic smp_vld_q, smp_first_q;
  logic [DATA_WIDTH-1:0] smp_q;

  logic [DATA_WIDTH-1:0] ring [NAVG];
  logic [PW-1:0] ptr_q, ptr_nxt;
  logic [SW-1:0] sum_q, sum_nxt;

  logic [DATA_WIDTH-1:0] per_q;
  logic per_vld_q;
  logic [1:0] dir_q;
  logic [DATA_WIDTH-1:0] pos_q;
  logic stall_q;
  logic ill_q;

  assign a_win = {a_sh, a_s2};
  assign b_win = {b_sh, b_s2};

  // Synchronize, debounce and remember the last filtered {A,B}.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_s1 <= 1'b0;
      a_s2 <= 1'b0;
      b_s1 <= 1'b0;
      b_s2 <= 1'b0;
      a_sh <= '0;
      b_sh <= '0;
      a_f  <= 1'b0;
      b_f  <= 1'b0;
      ab_p <= 2'b00;
    end else begin
      a_s1 <= encoder_a;
      a_s2 <= a_s1;
      b_s1 <= encoder_b;
      b_s2 <= b_s1;
      a_sh <= a_win[DEBOUNCE-2:0];
      b_sh <= b_win[DEBOUNCE-2:0];
      if (&a_win) a_f <= 1'b1;
      else if (~|a_win) a_f <= 1'b0;
      if (&b_win) b_f <= 1'b1;
      else if (~|b_win) b_f <= 1'b0;
      ab_p <= {a_f, b_f};
    end
  end

  // Gray position index: forward is +1, reverse -1, both-bit change 2.
  assign idx_p = {ab_p[0], ab_p[1] ^ ab_p[0]};
  assign idx_c = {b_f, a_f ^ b_f};
  assign idx_d = idx_c - idx_p;
  assign step_fwd = (idx_d == 2'd1);
  assign step_rev = (idx_d == 2'd3);
  assign step_ill = (idx_d == 2'd2);
  assign a_rise = a_f & ~ab_p[1];

  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + ONE;

  // Period FSM next state, counter and event decode.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    take = 1'b0;
    arm_hit = 1'b0;
    stall_hit = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      cnt_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          cnt_d = '0;
          state_d = ARM;
        end
        ARM: begin
          if (a_rise) begin
            cnt_d = ONE;
            state_d = MEASURE;
            arm_hit = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            stall_hit = (cnt_q == TIMEOUT);
          end
        end
        MEASURE: begin
          if (a_rise) begin
            cnt_d = ONE;
            take = 1'b1;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_q == TIMEOUT) begin
              stall_hit = 1'b1;
              state_d = ARM;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d = '0;
        end
      endcase
    end
  end

  // FSM state, period counter and preload flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (!enable) first_q <= 1'b0;
      else if (arm_hit) first_q <= 1'b1;
      else if (take) first_q <= 1'b0;
    end
  end

  // Capture the finished period one cycle after the edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      smp_vld_q   <= 1'b0;
      smp_first_q <= 1'b0;
      smp_q       <= '0;
    end else begin
      smp_vld_q <= take;
      if (take) begin
        smp_q       <= cnt_q;
        smp_first_q <= first_q;
      end
    end
  end

  assign ptr_nxt = (ptr_q == PW'(NAVG - 1)) ? '0 : ptr_q + 1'b1;

  // Running sum after this sample; first sample fills the window.
  always_comb begin
    if (smp_first_q) sum_nxt = SW'(smp_q) << AVG_LOG2;
    else sum_nxt = sum_q - SW'(ring[ptr_q]) + SW'(smp_q);
  end

  // Average window, decode results and status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NAVG; i++) ring[i] <= '0;
      ptr_q     <= '0;
      sum_q     <= '0;
      per_q     <= ONES;
      per_vld_q <= 1'b0;
      dir_q     <= 2'b00;
      pos_q     <= '0;
      stall_q   <= 1'b0;
      ill_q     <= 1'b0;
    end else begin
      per_vld_q <= 1'b0;
      ill_q     <= step_ill;
      unique case (1'b1)
        step_fwd: begin
          pos_q <= pos_q + ONE;
          dir_q <= 2'b10;
        end
        step_rev: begin
          pos_q <= pos_q - ONE;
          dir_q <= 2'b01;
        end
        default: ;
      endcase
      if (!enable) begin
        per_q   <= ONES;
        dir_q   <= 2'b00;
        stall_q <= 1'b0;
      end else if (stall_hit) begin
        per_q     <= ONES;
        per_vld_q <= 1'b1;
        dir_q     <= 2'b00;
        stall_q   <= 1'b1;
      end else begin
        if (a_rise) stall_q <= 1'b0;
        if (smp_vld_q) begin
          if (smp_first_q) begin
            for (int i = 0; i < NAVG; i++) ring[i] <= smp_q;
            ptr_q <= '0;
          end else begin
            ring[ptr_q] <= smp_q;
            ptr_q <= ptr_nxt;
          end
          sum_q     <= sum_nxt;
          per_q     <= DATA_WIDTH'(sum_nxt >> AVG_LOG2);
          per_vld_q <= 1'b1;
        end
      end
    end
  end

  assign meas.period_speed = per_q;
  assign meas.period_valid = per_vld_q;
  assign meas.direction    = dir_q;
  assign meas.position     = pos_q;
  assign meas.stalled      = stall_q;
  assign meas.illegal_edge = ill_q;

endmodule

// File: tb/tb_encoder_period_frontend.sv
// Scoreboard bench for encoder_period_frontend.
// Reference model works on raw edge times and a sample window.
module tb_encoder_period_frontend;
  localparam int DW = 16;
  localparam int DEB = 3;
  localparam int AVG = 2;
  localparam int NAVG = 1 << AVG;
  localparam int TMO = 2000;

  typedef struct {
    int val;
    bit stall;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;
  logic enc_a = 1'b0;
  logic enc_b = 1'b0;

  always #5 clk = ~clk;

  encoder_period_frontend_if #(.DATA_WIDTH(DW)) meas_if ();

  encoder_period_frontend #(
    .DATA_WIDTH(DW),
    .DEBOUNCE(DEB),
    .AVG_LOG2(AVG),
    .TIMEOUT(16'(TMO))
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .encoder_a(enc_a),
    .encoder_b(enc_b),
    .meas(meas_if)
  );

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int ill_cnt = 0;
  int last_vcyc = 0;
  exp_t expq[$];
  exp_t e;

  logic [1:0] seq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  int idx_m = 0;
  int pos_m = 0;
  int dir_m = 0;
  bit armed = 1'b1;
  bit first = 1'b0;
  int last_rise = 0;
  int win[$];
  int ill0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset && meas_if.period_valid) begin
      if (expq.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got period %0d expected none",
                 meas_if.period_speed);
      end else begin
        e = expq.pop_front();
        check("period_speed", 32'(meas_if.period_speed), e.val);
        check("stalled_at_strobe", 32'(meas_if.stalled), int'(e.stall));
        if (e.stall) check("stall_gap", 32'(cyc - last_vcyc), TMO - 1);
      end
      last_vcyc = cyc;
    end
    if (meas_if.illegal_edge) ill_cnt++;
  end

  task automatic rise_m();
    int p;
    int s;
    if (!enable) return;
    if (armed) begin
      armed = 1'b0;
      first = 1'b1;
      last_rise = cyc;
      return;
    end
    p = cyc - last_rise;
    last_rise = cyc;
    if (first) begin
      win.delete();
      repeat (NAVG) win.push_back(p);
      first = 1'b0;
    end else begin
      win.push_back(p);
      void'(win.pop_front());
    end
    s = 0;
    foreach (win[i]) s += win[i];
    expq.push_back('{s / NAVG, 1'b0});
  endtask

  task automatic step(int d);
    logic [1:0] o;
    logic [1:0] n;
    o = seq[idx_m];
    idx_m = (idx_m + d) & 3;
    n = seq[idx_m];
    {enc_a, enc_b} = n;
    pos_m += d;
    if (enable) dir_m = (d > 0) ? 2 : 1;
    if (!o[1] && n[1]) rise_m();
  endtask

  task automatic spin(int d, int n, int q);
    repeat (n) begin
      repeat (q) @(posedge clk);
      #1;
      step(d);
    end
  endtask

  task automatic chk_pos(string tag);
    repeat (12) @(posedge clk);
    #1;
    check({tag, "_position"}, 32'(meas_if.position), pos_m & 16'hFFFF);
    check({tag, "_direction"}, 32'(meas_if.direction), dir_m);
  endtask

  task automatic stall_wait(int n);
    expq.push_back('{16'hFFFF, 1'b1});
    armed = 1'b1;
    first = 1'b0;
    dir_m = 0;
    repeat (n) @(posedge clk);
    #1;
    check("stalled_level", 32'(meas_if.stalled), 1);
    check("stall_period", 32'(meas_if.period_speed), 16'hFFFF);
    check("stall_direction", 32'(meas_if.direction), 0);
  endtask

  task automatic set_enable(bit en);
    repeat (50) @(posedge clk);
    #1;
    enable = en;
    if (!en) begin
      dir_m = 0;
      @(posedge clk);
      #1;
      check("dis_period", 32'(meas_if.period_speed), 16'hFFFF);
      check("dis_valid", 32'(meas_if.period_valid), 0);
      check("dis_direction", 32'(meas_if.direction), 0);
      check("dis_stalled", 32'(meas_if.stalled), 0);
    end else begin
      armed = 1'b1;
      first = 1'b0;
    end
  endtask

  task automatic glitch_a();
    repeat (20) @(posedge clk);
    #1;
    enc_a = ~enc_a;
    repeat (2) @(posedge clk);
    #1;
    enc_a = ~enc_a;
    chk_pos("glitch");
  endtask

  task automatic flip_both();
    logic [1:0] o;
    logic [1:0] n;
    ill0 = ill_cnt;
    repeat (20) @(posedge clk);
    #1;
    o = seq[idx_m];
    idx_m = (idx_m + 2) & 3;
    n = seq[idx_m];
    {enc_a, enc_b} = n;
    if (!o[1] && n[1]) rise_m();
    chk_pos("illegal");
    check("illegal_pulses", 32'(ill_cnt - ill0), 1);
  endtask

  task automatic do_reset();
    repeat (50) @(posedge clk);
    #3;
    reset = 1'b0;
    enc_a = 1'b0;
    enc_b = 1'b0;
    idx_m = 0;
    pos_m = 0;
    dir_m = 0;
    armed = 1'b1;
    first = 1'b0;
    #1;
    check("rst_period", 32'(meas_if.period_speed), 16'hFFFF);
    check("rst_valid", 32'(meas_if.period_valid), 0);
    check("rst_position", 32'(meas_if.position), 0);
    check("rst_direction", 32'(meas_if.direction), 0);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #1;
    check("init_period", 32'(meas_if.period_speed), 16'hFFFF);
    check("init_valid", 32'(meas_if.period_valid), 0);
    check("init_direction", 32'(meas_if.direction), 0);
    check("init_position", 32'(meas_if.position), 0);
    check("init_stalled", 32'(meas_if.stalled), 0);
    check("init_illegal", 32'(meas_if.illegal_edge), 0);
    #2;
    reset = 1'b1;

    set_enable(1'b1);
    spin(1, 24, 100);
    chk_pos("fwd");
    spin(-1, 16, 100);
    chk_pos("rev");

    set_enable(1'b0);
    set_enable(1'b1);
    spin(1, 9, 100);
    spin(1, 8, 200);
    chk_pos("avg");

    stall_wait(TMO + 300);
    spin(1, 8, 100);
    chk_pos("resume");
    check("stall_cleared", 32'(meas_if.stalled), 0);

    glitch_a();
    flip_both();
    for (int i = 0; i < 3; i++)
      spin(1, 4, 80 + 40 * int'($urandom_range(0, 4)));
    chk_pos("rand");

    spin(1, 2, 100);
    set_enable(1'b0);
    chk_pos("disabled");
    set_enable(1'b1);
    spin(1, 12, 100);
    chk_pos("reenable");

    spin(1, 2, 100);
    do_reset();
    spin(-1, 3, 100);
    chk_pos("wrap");
    spin(1, 12, 100);
    chk_pos("after_reset");

    for (int i = 0; i < 50 && expq.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(expq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
